// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: binary-to-BCD converter (shift-add-3, one bit per cycle)
// feeding a time-multiplexed seven-segment scan. Digit 0 is least significant;
// a digit code of 4'hF blanks the shared decoder.
module ssd_scan_ctrl #(
  parameter int DIGITS      = 4,
  parameter int DATA_WIDTH  = 14,
  parameter int REFRESH_DIV = 50000,
  parameter int LZ_BLANK    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  busy,
  output logic                  ovf,
  output logic [3:0]            digit_code,
  output logic [DIGITS-1:0]     digit_sel
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + DATA_WIDTH;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int REF_W = $clog2(REFRESH_DIV);
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  // Largest value the display can show: 10^DIGITS - 1.
  function automatic logic [39:0] max_val_f();
    logic [39:0] m;
    m = 40'd1;
    for (int i = 0; i < DIGITS; i++) m = m * 40'd10;
    return m - 40'd1;
  endfunction

  localparam logic [39:0] MAX_VAL = max_val_f();

  // One double-dabble step over the combined {bcd, binary} shift register.
  function automatic logic [SR_W-1:0] dabble(input logic [SR_W-1:0] v);
    logic [SR_W-1:0] r;
    logic [3:0]      nib;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      nib = r[DATA_WIDTH + 4*i +: 4];
      if (nib >= 4'd5) r[DATA_WIDTH + 4*i +: 4] = nib + 4'd3;
    end
    return r << 1;
  endfunction

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_e;

  state_e                     state_q, state_d;
  logic [SR_W-1:0]            sr_q, sr_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       sat_q, sat_d;
  logic                       ovf_q, ovf_d;
  logic [DIGITS-1:0][3:0]     disp_q, disp_d;
  logic [REF_W-1:0]           ref_q, ref_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [DIGITS-1:0]          sel_q, sel_d;
  logic [3:0]                 code_q, code_d;
  logic                       in_ready_q, in_ready_d;
  logic                       busy_q, busy_d;

  logic [39:0]                in_ext;
  logic                       in_sat;
  logic [DATA_WIDTH-1:0]      load_val;
  logic [DIGITS-1:0][3:0]     bcd_digits;
  logic [DIGITS-1:0][3:0]     blanked;
  logic                       seen_nz;
  logic                       tick;

  // Saturate the incoming value to what the display can represent.
  always_comb begin
    in_ext   = 40'(in_data);
    in_sat   = (in_ext > MAX_VAL);
    load_val = in_sat ? MAX_VAL[DATA_WIDTH-1:0] : in_data;
  end

  // Leading-zero blanking of the finished BCD digits, scanning from the top.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    bcd_digits = sr_q[DATA_WIDTH +: BCD_W];
    blanked    = bcd_digits;
    seen_nz    = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if ((LZ_BLANK != 0) && (i != 0) && !seen_nz && (bcd_digits[i] == 4'h0))
        blanked[i] = 4'hF;
      if (bcd_digits[i] != 4'h0) seen_nz = 1'b1;
    end
  end

  // Next-state logic: conversion FSM, scan counter and registered outputs.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    ovf_d   = ovf_q;
    disp_d  = disp_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sr_d    = {{BCD_W{1'b0}}, load_val};
          sat_d   = in_sat;
          cnt_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        sr_d  = dabble(sr_q);
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DATA_WIDTH - 1)) state_d = COMMIT;
      end
      COMMIT: begin
        disp_d  = blanked;
        ovf_d   = sat_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);

    // Scan runs freely; the outputs are computed from next-cycle index and
    // display so a commit and an index change land on the same edge.
    tick  = (ref_q == REF_W'(REFRESH_DIV - 1));
    ref_d = tick ? '0 : ref_q + 1'b1;
    idx_d = idx_q;
    if (tick) idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;

    sel_d  = '1;
    code_d = 4'hF;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        sel_d[i] = 1'b0;
        code_d   = disp_d[i];
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      cnt_q      <= '0;
      sat_q      <= 1'b0;
      ovf_q      <= 1'b0;
      // NOTE: display registers are reset because "blank" is a visible state on the board.
      disp_q     <= {DIGITS{4'hF}};
      ref_q      <= '0;
      idx_q      <= '0;
      sel_q      <= ~{{(DIGITS-1){1'b0}}, 1'b1};
      code_q     <= 4'hF;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      sat_q      <= sat_d;
      ovf_q      <= ovf_d;
      disp_q     <= disp_d;
      ref_q      <= ref_d;
      idx_q      <= idx_d;
      sel_q      <= sel_d;
      code_q     <= code_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign busy       = busy_q;
  assign ovf        = ovf_q;
  assign digit_code = code_q;
  assign digit_sel  = sel_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// tb_ssd_scan_ctrl: scoreboard bench. Two instances share the stimulus, one
// with leading-zero blanking and one without; expected displays are queued
// at each transfer and checked continuously against the scanned outputs.
module tb_ssd_scan_ctrl;

  localparam int DW = 14;
  localparam int RD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;

  logic       in_ready, busy, ovf;
  logic [3:0] code;
  logic [3:0] sel;
  logic       in_ready0, busy0, ovf0;
  logic [3:0] code0;
  logic [3:0] sel0;

  ssd_scan_ctrl #(.DIGITS(4), .DATA_WIDTH(DW), .REFRESH_DIV(RD), .LZ_BLANK(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .busy(busy), .ovf(ovf),
    .digit_code(code), .digit_sel(sel)
  );

  ssd_scan_ctrl #(.DIGITS(4), .DATA_WIDTH(DW), .REFRESH_DIV(RD), .LZ_BLANK(0)) dut_nolz (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready0), .busy(busy0), .ovf(ovf0),
    .digit_code(code0), .digit_sel(sel0)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at cycle", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] d1;
    logic [15:0] d0;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t q[$];

  // Cycle count, reset seen at the last edge, and the free-running scan model.
  int   cyc = 0;
  logic rst_seen = 1'b0;
  int   m_ref = 0;
  int   m_idx = 0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
    if (rst) begin
      m_ref <= 0;
      m_idx <= 0;
    end else if (m_ref == RD - 1) begin
      m_ref <= 0;
      m_idx <= (m_idx == 3) ? 0 : m_idx + 1;
    end else begin
      m_ref <= m_ref + 1;
    end
  end

  // Monitor: pops on each commit (busy falling) and checks the scan every cycle.
  bit          mon_en = 1'b0;
  bit          busy_prev = 1'b0;
  logic [15:0] exp_d1 = 16'hFFFF;
  logic [15:0] exp_d0 = 16'hFFFF;
  logic        exp_ovf = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      logic [3:0] s;
      exp_t       e;
      if (rst_seen) begin
        q.delete();
        exp_d1  = 16'hFFFF;
        exp_d0  = 16'hFFFF;
        exp_ovf = 1'b0;
      end else if (busy_prev && !busy) begin
        if (q.size() == 0) begin
          check("unexpected_commit", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check("commit_cycle", cyc, e.cyc);
          check("ready_after_commit", {31'd0, in_ready}, 32'd1);
          exp_d1  = e.d1;
          exp_d0  = e.d0;
          exp_ovf = e.ovf;
        end
      end
      busy_prev = busy;
      s = 4'b0001 << m_idx;
      check("digit_sel", {28'd0, sel}, {28'd0, ~s});
      check("digit_sel_nolz", {28'd0, sel0}, {28'd0, ~s});
      check("digit_code", {28'd0, code}, {28'd0, exp_d1[m_idx*4 +: 4]});
      check("digit_code_nolz", {28'd0, code0}, {28'd0, exp_d0[m_idx*4 +: 4]});
      check("ovf", {31'd0, ovf}, {31'd0, exp_ovf});
      check("ovf_nolz", {31'd0, ovf0}, {31'd0, exp_ovf});
      check("busy_match", {31'd0, busy0}, {31'd0, busy});
    end
  end

  // Wait for in_ready, offer one value and queue its hand-computed display.
  task automatic load(input logic [DW-1:0] v, input logic [15:0] e1,
                      input logic [15:0] e0, input logic eo);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("load_timeout", 32'd1, 32'd0);
    in_valid = 1'b1;
    in_data  = v;
    q.push_back('{d1: e1, d0: e0, ovf: eo, cyc: cyc + 1 + DW + 1});
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("ready_drop", {31'd0, in_ready}, 32'd0);
    check("busy_rise", {31'd0, busy}, 32'd1);
  endtask

  initial begin
    int n;
    // Reset held for two edges.
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_code", {28'd0, code}, 32'hF);
    check("rst_sel", {28'd0, sel}, 32'hE);
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    mon_en = 1'b1;
    rst = 1'b0;
    @(negedge clk);

    load(14'd1234, 16'h1234, 16'h1234, 1'b0);
    repeat (40) @(negedge clk);
    load(14'd7,     16'hFFF7, 16'h0007, 1'b0);
    load(14'd0,     16'hFFF0, 16'h0000, 1'b0);
    load(14'd12000, 16'h9999, 16'h9999, 1'b1);
    repeat (20) @(negedge clk);
    load(14'd5,     16'hFFF5, 16'h0005, 1'b0);
    repeat (20) @(negedge clk);

    // Value offered during CONV is ignored until in_ready returns.
    load(14'd808, 16'hF808, 16'h0808, 1'b0);
    in_valid = 1'b1;
    in_data  = 14'd42;
    load(14'd42, 16'hFF42, 16'h0042, 1'b0);
    repeat (20) @(negedge clk);

    // Reset in the middle of a conversion discards it.
    load(14'd4321, 16'h4321, 16'h4321, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid_ready", {31'd0, in_ready}, 32'd1);
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    check("rstmid_code", {28'd0, code}, 32'hF);
    @(negedge clk);
    load(14'd56, 16'hFF56, 16'h0056, 1'b0);

    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", q.size(), 32'd0);
    repeat (20) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
